// File: rtl/text_buf_arbiter.sv
// text_buf_arbiter: 8-slot glyph-address buffer for the VGA text line.
// A single access port is shared between VGA glyph fetches (always win) and
// edit commands from the morse path (push / backspace / clear). Edits wait in
// a one-deep pending register, and clear sweeps the slots one per free cycle.
module text_buf_arbiter #(
  parameter int                NUM_CHARS  = 8,
  parameter int                IDX_W      = 3,
  parameter int                CODE_W     = 11,
  parameter logic [CODE_W-1:0] BLANK_CODE = 11'h000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_push,
  input  logic [CODE_W-1:0] i_push_code,
  input  logic              i_cmd_back,
  input  logic              i_cmd_clear,
  input  logic              i_rd_req,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [CODE_W-1:0] o_rd_code,
  output logic [IDX_W:0]    o_char_count,
  output logic [IDX_W-1:0]  o_cursor_idx,
  output logic              o_full,
  output logic              o_busy,
  output logic              o_drop,
  output logic              o_overflow
);

  localparam logic [IDX_W:0]   CNT_ZERO = (IDX_W+1)'(0);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W+1)'(NUM_CHARS);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHARS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_pend_vld;
  logic                r_pend_push;   // 1: push, 0: backspace
  logic [CODE_W-1:0]   r_pend_code;
  logic [IDX_W-1:0]    r_clr_ptr;
  logic [IDX_W:0]      r_count;
  logic [IDX_W-1:0]    r_cursor;
  logic                r_busy;
  logic                r_drop;
  logic                r_overflow;
  logic                r_rd_valid;
  logic [CODE_W-1:0]   r_rd_code;
  logic [CODE_W-1:0]   r_slots [NUM_CHARS];

  state_t              w_state_nxt;
  logic                w_pend_vld_nxt;
  logic                w_pend_push_nxt;
  logic [CODE_W-1:0]   w_pend_code_nxt;
  logic [IDX_W-1:0]    w_clr_ptr_nxt;
  logic [IDX_W:0]      w_count_nxt;
  logic [IDX_W-1:0]    w_cursor_nxt;
  logic                w_busy_nxt;
  logic                w_drop_nxt;
  logic                w_overflow_nxt;
  logic                w_wr_en;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [CODE_W-1:0]   w_wr_data;
  logic                w_any_cmd;

  assign w_any_cmd = i_cmd_push | i_cmd_back | i_cmd_clear;

  // Next-state, pending-register, counter and single write-port control.
  always_comb begin
    w_state_nxt     = r_state;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_push_nxt = r_pend_push;
    w_pend_code_nxt = r_pend_code;
    w_clr_ptr_nxt   = r_clr_ptr;
    w_count_nxt     = r_count;
    w_overflow_nxt  = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_idx        = IDX_ZERO;
    w_wr_data       = BLANK_CODE;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_vld) begin
          // A pending edit only touches the buffer on a read-free edge.
          if (!i_rd_req) begin
            w_pend_vld_nxt = 1'b0;
            if (r_pend_push) begin
              if (r_count == CNT_MAX) begin
                w_overflow_nxt = 1'b1;
              end else begin
                w_wr_en     = 1'b1;
                w_wr_idx    = r_count[IDX_W-1:0];
                w_wr_data   = r_pend_code;
                w_count_nxt = r_count + CNT_ONE;
              end
            end else begin
              if (r_count == CNT_ZERO) begin
                w_overflow_nxt = 1'b1;
              end else begin
                w_wr_en     = 1'b1;
                w_wr_idx    = r_count[IDX_W-1:0] - IDX_ONE;
                w_wr_data   = BLANK_CODE;
                w_count_nxt = r_count - CNT_ONE;
              end
            end
          end else begin
            w_pend_vld_nxt = 1'b1;
          end
        end else if (i_cmd_clear) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = IDX_ZERO;
          w_count_nxt   = CNT_ZERO;
        end else if (i_cmd_back) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_push_nxt = 1'b0;
        end else if (i_cmd_push) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_push_nxt = 1'b1;
          w_pend_code_nxt = i_push_code;
        end else begin
          w_pend_vld_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (!i_rd_req) begin
          w_wr_en       = 1'b1;
          w_wr_idx      = r_clr_ptr;
          w_wr_data     = BLANK_CODE;
          w_clr_ptr_nxt = r_clr_ptr + IDX_ONE;
          if (r_clr_ptr == IDX_LAST) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_CLEAR;
          end
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_pend_vld_nxt = 1'b0;
      end
    endcase
  end

  // Derived status values for the next cycle (busy, drop, cursor).
  always_comb begin
    w_busy_nxt = w_pend_vld_nxt | (w_state_nxt == ST_CLEAR);
    w_drop_nxt = r_busy & w_any_cmd;
    if (w_count_nxt == CNT_ZERO) begin
      w_cursor_nxt = IDX_ZERO;
    end else begin
      w_cursor_nxt = w_count_nxt[IDX_W-1:0] - IDX_ONE;
    end
  end

  // Control state registers: FSM, pending command, counters and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_push <= 1'b0;
      r_pend_code <= BLANK_CODE;
      r_clr_ptr   <= IDX_ZERO;
      r_count     <= CNT_ZERO;
      r_cursor    <= IDX_ZERO;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_push <= w_pend_push_nxt;
      r_pend_code <= w_pend_code_nxt;
      r_clr_ptr   <= w_clr_ptr_nxt;
      r_count     <= w_count_nxt;
      r_cursor    <= w_cursor_nxt;
      r_busy      <= w_busy_nxt;
      r_drop      <= w_drop_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  // Slot storage: reset to blank, otherwise one write per read-free cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_slots[i] <= BLANK_CODE;
      end
    end else if (w_wr_en) begin
      r_slots[w_wr_idx] <= w_wr_data;
    end else begin
      r_slots[w_wr_idx] <= r_slots[w_wr_idx];
    end
  end

  // VGA fetch path: fixed one-cycle latency in every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_code  <= {CODE_W{1'b0}};
    end else begin
      r_rd_valid <= i_rd_req;
      if (i_rd_req) begin
        r_rd_code <= r_slots[i_rd_idx];
      end else begin
        r_rd_code <= r_rd_code;
      end
    end
  end

  assign o_rd_valid   = r_rd_valid;
  assign o_rd_code    = r_rd_code;
  assign o_char_count = r_count;
  assign o_cursor_idx = r_cursor;
  assign o_full       = (r_count == CNT_MAX);
  assign o_busy       = r_busy;
  assign o_drop       = r_drop;
  assign o_overflow   = r_overflow;

endmodule

// File: doc/text_buf_arbiter.md
Name: text_buf_arbiter

Overview:
- Owns an 8-slot character buffer holding ASCII-ROM glyph base addresses (11-bit, e.g. 'A' = 11'h410). The buffer backs the multi-character VGA text line.
- Serialises edit commands from the morse path (push committed letter, backspace, clear) against glyph fetches from the VGA pixel pipeline. The buffer has one access port, so only one access happens per clock.
- VGA reads always win. Edits are held in a one-deep pending register until a read-free cycle.
- Sits between the morse encoder / letter-mapping logic and the VGA controller, and replaces the single fixed-address path.

Parameters:
- NUM_CHARS, 8, number of buffer slots; must be a power of two.
- IDX_W, 3, slot index width; equals log2(NUM_CHARS).
- CODE_W, 11, glyph address width.
- BLANK_CODE, 11'h000, glyph address written on reset, backspace and clear.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_push  in  1  single-cycle pulse: append push_code at the cursor.
- push_code  in  CODE_W  glyph address for push; sampled with cmd_push.
- cmd_back  in  1  single-cycle pulse: delete the last character.
- cmd_clear  in  1  single-cycle pulse: blank all slots.
- rd_req  in  1  VGA glyph fetch request.
- rd_idx  in  IDX_W  slot to fetch.
- rd_valid  out  1  fetch data valid.
- rd_code  out  CODE_W  fetched glyph address.
- char_count  out  IDX_W+1  number of characters held (0..NUM_CHARS).
- cursor_idx  out  IDX_W  index of the last character; 0 when the buffer is empty.
- full  out  1  char_count == NUM_CHARS.
- busy  out  1  command pending or clear in progress.
- drop  out  1  one-cycle pulse: command lost because the block was busy.
- overflow  out  1  one-cycle pulse: push while full, or back while empty.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - All slots become BLANK_CODE.
  - rd_valid = 0, rd_code = 0, char_count = 0, busy = 0, drop = 0, overflow = 0.
  - State machine returns to IDLE; pending register is cleared.
  - Reset asserted mid-clear or with a command pending abandons it completely.
- Read path:
  - rd_req sampled at edge N gives rd_valid = 1 and rd_code = slot[rd_idx] after edge N.
  - Latency is exactly 1 cycle, in every state.
  - rd_valid is low in any cycle following an edge where rd_req = 0.
- Command intake:
  - Commands are sampled only in IDLE with no pending command.
  - Same-cycle priority is clear > back > push. Lower-priority commands are discarded silently, with no drop pulse.
  - Any command sampled while busy = 1 is discarded and drop pulses for 1 cycle.
- States:
  - IDLE: a sampled push or back loads the pending register (op, code). busy rises at the same edge. A sampled clear goes to CLEAR with clr_ptr = 0, forces char_count to 0 and raises busy.
  - Pending commit (IDLE with pending set): at the first edge where rd_req = 0:
    - push: slot[char_count] <= code, char_count + 1.
    - back: slot[char_count - 1] <= BLANK_CODE, char_count - 1.
    - The pending register clears and busy falls at that edge.
    - Minimum latency from command sample to char_count update is 1 edge.
    - The commit waits indefinitely while rd_req stays high.
  - Full / empty handling is checked at commit:
    - push with full = 1: no write, no count change, overflow pulses.
    - back with char_count = 0: no write, no count change, overflow pulses.
    - busy still falls in both cases.
  - CLEAR: at each edge with rd_req = 0, slot[clr_ptr] <= BLANK_CODE and clr_ptr increments.
    - After the write to slot NUM_CHARS-1, return to IDLE and drop busy.
    - Clear therefore takes exactly NUM_CHARS read-free edges.
    - Reads during CLEAR return whatever the slot currently holds, which may be partially cleared.
- Arithmetic and widths:
  - char_count never exceeds NUM_CHARS and never wraps.
  - cursor_idx = char_count - 1, truncated to IDX_W bits; 0 when char_count = 0.
  - full is a combinational decode of char_count.
- Read/write hazard: a write never occurs in a cycle with rd_req = 1, so no read-during-write hazard exists.

Test Plan:
- Reset, then read slots 0..7 → rd_code = 11'h000 each time, rd_valid exactly 1 cycle after each rd_req. char_count = 0, cursor_idx = 0.
- Push 11'h410, 11'h420, 11'h430 with rd_req low → char_count = 3, cursor_idx = 2. Reading slot 1 returns 11'h420.
- Hold rd_req high for 20 cycles, then push 11'h540 → busy stays high and char_count is unchanged until rd_req drops. Write commits at that edge; a second push during the wait gives a drop pulse and is lost.
- Fill with 8 pushes, then push 11'h590 → overflow pulses and slot contents are unchanged. Then 9 backs → char_count reaches 0, slot[7..0] = 11'h000, overflow pulses on the 9th back.
- Clear with rd_req toggling every other cycle → busy high for exactly 8 rd_req-low edges and all slots read back 11'h000. A push mid-clear gives a drop pulse.
- Same-cycle cmd_push + cmd_back with char_count = 2 → back wins, char_count = 1, no drop. Assert rst_n = 0 mid-clear → all outputs return to reset values immediately.
